// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and default widths for the CORDIC scheduler
//
// Purpose: scheduler FSM state encoding and default parameter values.
// Ports:   none (package).
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_ITERATION_WIDTH = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 64;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first active request at or after last_id+1 (wrapping).
// Ports:
//   req      in   NUM_REQ   request vector
//   last_id  in   ID_WIDTH  index of the most recently served requester
//   gnt      out  NUM_REQ   one-hot winner (all zero when no request)
//   id       out  ID_WIDTH  encoded winner
//   any      out  1         at least one request active
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_id,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] id,
  output logic                any
);

  logic [ID_WIDTH-1:0] idx;

  // Scan starts one past the last winner, so last_id itself is checked last.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(last_id) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// rtl/cordic_scheduler.sv - round-robin scheduler sharing one CORDIC vectoring core
//
// Purpose: arbitrates NUM_REQ requesters onto a single CORDIC core, launches
// one job at a time and returns the angle result with a valid/ready handshake.
// Optional feature: define CORDIC_SCHED_TIMEOUT_EN for a WAIT watchdog that
// forces an error response after TIMEOUT_CYCLES.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req                       per-requester request level
//   req_x, req_y              packed operands, slice i for requester i
//   cfg_n                     iteration count forwarded to the core
//   gnt                       one-hot grant pulse
//   core_start/x/y/n          core launch interface
//   core_done, core_z         core idle/done level and angle result
//   res_valid/id/z/err        result, held until res_ready
//   res_ready                 result accept
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ITERATION_WIDTH = DEF_ITERATION_WIDTH,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
  input  logic [ITERATION_WIDTH-1:0]    cfg_n,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          core_start,
  output logic [DATA_WIDTH-1:0]         core_x,
  output logic [DATA_WIDTH-1:0]         core_y,
  output logic [ITERATION_WIDTH-1:0]    core_n,
  input  logic                          core_done,
  input  logic [DATA_WIDTH-1:0]         core_z,
  output logic                          res_valid,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  output logic [DATA_WIDTH-1:0]         res_z,
  output logic                          res_err,
  input  logic                          res_ready
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cordic_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t              state;
  logic [IDW-1:0]      last_id;
  logic                wait_first;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDW-1:0]      arb_id;
  logic                arb_any;
  logic [DATA_WIDTH-1:0] sel_x;
  logic [DATA_WIDTH-1:0] sel_y;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(IDW)
  ) u_arb (
    .req    (req),
    .last_id(last_id),
    .gnt    (arb_gnt),
    .id     (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_x = req_x[i*DATA_WIDTH +: DATA_WIDTH];
        sel_y = req_y[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      core_start <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
      core_n     <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_z      <= '0;
      last_id    <= IDW'(NUM_REQ - 1);
      wait_first <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      res_err    <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      gnt        <= '0;
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Launch only when the core reports idle; res_id doubles as the
          // record of the job in flight.
          if (arb_any && core_done) begin
            gnt        <= arb_gnt;
            core_x     <= sel_x;
            core_y     <= sel_y;
            core_n     <= cfg_n;
            res_id     <= arb_id;
            core_start <= 1'b1;
            state      <= ST_ISSUE;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            res_err    <= 1'b0;
`endif
          end
        end
        ST_ISSUE: begin
          wait_first <= 1'b1;
          state      <= ST_WAIT;
`ifdef CORDIC_SCHED_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
        end
        ST_WAIT: begin
          wait_first <= 1'b0;
          // The core may still show the previous done level in the cycle
          // right after start, so that cycle is not trusted.
          if (!wait_first && core_done) begin
            res_z     <= core_z;
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end
`ifdef CORDIC_SCHED_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            res_z     <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            last_id   <= res_id;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// tb/tb_cordic_scheduler.sv - directed self-checking bench for cordic_scheduler
module tb_cordic_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [3:0]  cfg_n;
  logic [3:0]  gnt;
  logic        core_start;
  logic [15:0] core_x;
  logic [15:0] core_y;
  logic [3:0]  core_n;
  logic        core_done;
  logic [15:0] core_z;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [15:0] res_z;
  logic        res_err;
  logic        res_ready;

  int vectors     = 0;
  int miscompares = 0;

  int core_lat  = 3;
  int core_lag  = 0;
  bit core_hang = 1'b0;
  int cc;

  logic [15:0] op_x [4];
  logic [15:0] op_y [4];

  always #5 clk = ~clk;

  cordic_scheduler #(
    .NUM_REQ        (4),
    .DATA_WIDTH     (16),
    .ITERATION_WIDTH(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .cfg_n     (cfg_n),
    .gnt       (gnt),
    .core_start(core_start),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_n    (core_n),
    .core_done (core_done),
    .core_z    (core_z),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_z     (res_z),
    .res_err   (res_err),
    .res_ready (res_ready)
  );

  // Core model: done drops core_lag cycles after start (stays high before),
  // stays low core_lat cycles, result z = x + 2y.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_done <= 1'b1;
      core_z    <= '0;
      cc        <= 0;
    end else if (core_start) begin
      core_z    <= core_x + (core_y << 1);
      cc        <= 1;
      core_done <= (core_lag > 0);
    end else if (cc != 0) begin
      if (cc < core_lag) begin
        core_done <= 1'b1;
        cc        <= cc + 1;
      end else if (cc < core_lag + core_lat || core_hang) begin
        core_done <= 1'b0;
        cc        <= cc + 1;
      end else begin
        core_done <= 1'b1;
        cc        <= 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] zf(input int i);
    return op_x[i] + {op_y[i][14:0], 1'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] x, input logic [15:0] y);
    op_x[i] = x;
    op_y[i] = y;
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
  endtask

  // Waits for the grant; leaves the bench at the negedge of the grant cycle.
  task automatic serve_grant(input int id, input logic [3:0] clr);
    int n;
    logic [3:0] one;
    one = 4'b0001;
    n = 0;
    while (gnt == 4'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("gnt_onehot", gnt, one << id);
    chk("core_start", core_start, 1'b1);
    chk("core_x", core_x, op_x[id]);
    chk("core_y", core_y, op_y[id]);
    chk("core_n", core_n, cfg_n);
    req = req & ~clr;
  endtask

  task automatic serve_result(input int id, input int exp_lat);
    int n;
    tick();
    n = 1;
    chk("pulse_width", {gnt, core_start}, 5'b0);
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    chk("latency", n, exp_lat);
    chk("res_id", res_id, id);
    chk("res_z", res_z, zf(id));
    chk("res_err", res_err, 1'b0);
  endtask

  task automatic accept();
    tick();
    chk("accept_gap", {res_valid, gnt}, 5'b0);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    req       = '0;
    req_x     = '0;
    req_y     = '0;
    cfg_n     = 4'd8;
    res_ready = 1'b1;
    set_ops(0, 16'd100, 16'd100);
    set_ops(1, 16'h1234, 16'h0011);
    set_ops(2, 16'h0F00, 16'h00F0);
    set_ops(3, 16'hFFFF, 16'h0001);
    tick(); tick(); tick();

    chk("rst_gnt", gnt, 4'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_x", core_x, 16'h0);
    chk("rst_core_y", core_y, 16'h0);
    chk("rst_core_n", core_n, 4'h0);
    chk("rst_res", {res_valid, res_id, res_err}, 4'b0);
    chk("rst_res_z", res_z, 16'h0);
    rst = 1'b1;
    tick();

    // Single request from requester 0; z = 100 + 200
    req = 4'b0001;
    serve_grant(0, 4'b0001);
    serve_result(0, 5);
    chk("single_z", res_z, 16'd300);
    accept();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt != 4'b0 || res_valid) n++;
    end
    chk("single_no_repeat", n, 0);
    chk("core_x_hold", core_x, 16'd100);

    // All four at once from a fresh reset: 0,1,2,3
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    cfg_n = 4'd5;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] m;
      m = 4'b0001 << i;
      serve_grant(i, m);
      serve_result(i, 5);
      accept();
    end

    // Back-pressure with requester 2 pending behind requester 1
    req = 4'b0110;
    serve_grant(1, 4'b0010);
    res_ready = 1'b0;
    serve_result(1, 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {res_valid, res_id, res_z, gnt}, {1'b1, 2'd1, zf(1), 4'b0});
    end
    res_ready = 1'b1;
    tick();
    chk("bp_accept", {res_valid, gnt}, 5'b0);
    tick();
    chk("bp_next_gnt", gnt, 4'b0100);
    serve_grant(2, 4'b0100);
    serve_result(2, 5);
    accept();

    // Fairness: 0 and 1 held continuously, last winner was 2
    core_lat = 1;
    req = 4'b0011;
    for (int j = 0; j < 6; j++) begin
      serve_grant(j % 2, (j == 5) ? 4'b0011 : 4'b0000);
      serve_result(j % 2, 3);
      accept();
    end

    // Core holds done high one extra cycle after start
    core_lag = 1;
    core_lat = 2;
    req = 4'b0100;
    serve_grant(2, 4'b0100);
    serve_result(2, 5);
    accept();
    core_lag = 0;

    // Reset in WAIT abandons the job and restores priority to requester 0
    core_lat = 10;
    req = 4'b1000;
    serve_grant(3, 4'b1000);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {gnt, core_start, res_valid, res_err, res_id}, 9'b0);
    chk("mid_rst_core", {core_x, core_y, core_n}, 36'b0);
    chk("mid_rst_res_z", res_z, 16'h0);
    tick(); tick();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (res_valid || gnt != 4'b0) n++;
    end
    chk("mid_rst_no_result", n, 0);
    core_lat = 2;
    req = 4'b1001;
    serve_grant(0, 4'b1001);
    serve_result(0, 4);
    accept();

    // Hung core
    core_hang = 1'b1;
    req = 4'b1000;
    serve_grant(3, 4'b1000);
`ifdef CORDIC_SCHED_TIMEOUT_EN
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 9);
    chk("tmo_res", {res_valid, res_err, res_id}, 4'b1111);
    chk("tmo_res_z", res_z, 16'h0);
    core_hang = 1'b0;
    tick();
    chk("tmo_accept", res_valid, 1'b0);
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) n++;
    end
    chk("hang_no_result", n, 0);
    core_hang = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    chk("hang_release", {res_valid, res_err, res_id}, 4'b1011);
    chk("hang_res_z", res_z, zf(3));
    accept();
`endif
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
